req_fifo_ctl: RTL and testbench

- Parametrised successor of the request FIFO buffer. Single-clock, power-of-two-deep request queue.
- Adds:
  - selectable standard (registered-read) or first-word-fall-through (FWFT) mode
  - exact occupancy and space counters
  - programmable almost-full and almost-empty thresholds
  - sticky overflow and underflow error flags
  - correct gating when read and write happen in the same cycle
- Sits between the request generator and the PHY/TX scheduler. The scheduler uses `space` and `almost_full` for backpressure.

---
 rtl/req_buf_pkg.sv | 23 ++
 rtl/req_fifo_mem.sv | 39 +++
 rtl/req_fifo_ctl.sv | 156 +++++++++++++++
 tb/tb_req_fifo_ctl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/req_buf_pkg.sv
// Shared types and constants for the request FIFO family.
// Holds the read-mode enumeration, the capacity helper and the
// default almost-full / almost-empty threshold values.
package req_buf_pkg;

  // Read-side behaviour of the queue.
  typedef enum logic {
    MODE_STD  = 1'b0,  // registered read, one-cycle data latency
    MODE_FWFT = 1'b1   // head word presented before it is popped
  } fifo_mode_e;

  // Almost-full asserts this many entries below capacity by default.
  localparam int DEF_AF_MARGIN = 4;

  // Almost-empty asserts at or below this occupancy by default.
  localparam int DEF_AE_THRESH = 2;

  // Entry count for a queue addressed by a depth-bit pointer.
  function automatic int fifo_cap(input int depth);
    return 1 << depth;
  endfunction

endpackage

// File: rtl/req_fifo_mem.sv
// Simple dual-port RAM for the request FIFO: one synchronous write
// port, one synchronous read port with a read enable. No reset on
// the array or on the read register so the tools map it to block RAM.
module req_fifo_mem #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [DEPTH-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [DEPTH-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  localparam int ENTRIES = 1 << DEPTH;

  logic [WIDTH-1:0] mem_q [0:ENTRIES-1];
  logic [WIDTH-1:0] rdata_q;

  // Write port: store the word on an accepted write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read port: the read register only changes on a read, so the last
  // word read stays on the output between reads.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/req_fifo_ctl.sv
// Request FIFO controller: pointers, exact occupancy/space counters,
// threshold flags and sticky error flags around a block-RAM queue.
// In standard mode a read returns data one cycle later; in FWFT mode
// the RAM read register doubles as the head-of-queue output register.
module req_fifo_ctl
  import req_buf_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 6,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = fifo_cap(DEPTH) - DEF_AF_MARGIN,
  parameter int AE_THRESH = DEF_AE_THRESH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] w_data,
  input  logic             rd,
  input  logic             clr_err,
  output logic [WIDTH-1:0] r_data,
  output logic             r_data_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [DEPTH:0]   count,
  output logic [DEPTH:0]   space,
  output logic             overflow,
  output logic             underflow
);

  localparam int             CAP   = fifo_cap(DEPTH);
  localparam fifo_mode_e     MODE  = (FWFT != 0) ? MODE_FWFT : MODE_STD;
  localparam logic [DEPTH:0] CAP_C = (DEPTH+1)'(CAP);
  localparam logic [DEPTH:0] AF_C  = (DEPTH+1)'(AF_THRESH);
  localparam logic [DEPTH:0] AE_C  = (DEPTH+1)'(AE_THRESH);

  logic [DEPTH-1:0] w_ptr_q, w_ptr_d;
  logic [DEPTH-1:0] r_ptr_q, r_ptr_d;
  logic [DEPTH:0]   count_q, count_d;
  logic [DEPTH:0]   space_q, space_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             af_q, af_d;
  logic             ae_q, ae_d;
  logic             valid_q, valid_d;
  logic             seen_q, seen_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             wr_acc;
  logic             rd_acc;
  logic             mem_re;
  logic [DEPTH:0]   stored;
  logic [WIDTH-1:0] mem_rdata;

  // Acceptance, RAM read enable and next-state for every counter and flag.
  always_comb begin
    wr_acc  = wr & ~full_q;
    rd_acc  = rd & ~empty_q;
    // Words sitting in the RAM only; the FWFT head word is excluded.
    // count_q does not yet include a write landing on this edge, so
    // only words written at least one cycle earlier can be prefetched.
    stored  = count_q - (DEPTH+1)'(valid_q);
    mem_re  = 1'b0;
    valid_d = 1'b0;

    if (MODE == MODE_FWFT) begin
      mem_re = (~valid_q | rd_acc) & (stored != '0);
      if (mem_re) begin
        valid_d = 1'b1;
      end else if (rd_acc) begin
        valid_d = 1'b0;
      end else begin
        valid_d = valid_q;
      end
    end else begin
      mem_re  = rd_acc;
      valid_d = rd_acc;
    end

    count_d = count_q + (DEPTH+1)'(wr_acc) - (DEPTH+1)'(rd_acc);
    space_d = CAP_C - count_d;
    full_d  = (count_d == CAP_C);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);
    empty_d = (MODE == MODE_FWFT) ? ~valid_d : (count_d == '0);

    w_ptr_d = w_ptr_q + DEPTH'(wr_acc);
    r_ptr_d = r_ptr_q + DEPTH'(mem_re);

    // r_data shows zero until the first word has been read after reset.
    seen_d  = seen_q | mem_re;

    // A new error in the same cycle as clr_err keeps the flag set.
    ovf_d   = (ovf_q & ~clr_err) | (wr & full_q);
    unf_d   = (unf_q & ~clr_err) | (rd & empty_q);
  end

  // State register; reset discards queued data and any in-flight read.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      count_q <= '0;
      space_q <= CAP_C;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      valid_q <= 1'b0;
      seen_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      count_q <= count_d;
      space_q <= space_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      valid_q <= valid_d;
      seen_q  <= seen_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // RAM accesses are suppressed while reset is asserted.
  req_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc & reset_n),
    .waddr (w_ptr_q),
    .wdata (w_data),
    .re    (mem_re & reset_n),
    .raddr (r_ptr_q),
    .rdata (mem_rdata)
  );

  assign r_data       = seen_q ? mem_rdata : '0;
  assign r_data_valid = valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign space        = space_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_req_fifo_ctl.sv
// Self-checking bench for req_fifo_ctl: a standard-mode and an FWFT-mode
// instance share one stimulus stream. A queue-based reference model
// predicts every output each cycle; a vector table and directed
// sequences add fixed expectations for the corner cases.
module tb_req_fifo_ctl;

  localparam int W   = 64;
  localparam int D   = 6;
  localparam int CAP = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n = 1'b0;
  logic         wr = 1'b0, rd = 1'b0, clr_err = 1'b0;
  logic [W-1:0] w_data = '0;

  logic [W-1:0] s_rdata, f_rdata;
  logic         s_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic         f_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [D:0]   s_count, s_space, f_count, f_space;

  req_fifo_ctl #(.WIDTH(W), .DEPTH(D), .FWFT(0)) u_std (
    .clk(clk), .reset_n(reset_n), .wr(wr), .w_data(w_data), .rd(rd),
    .clr_err(clr_err), .r_data(s_rdata), .r_data_valid(s_valid),
    .full(s_full), .empty(s_empty), .almost_full(s_af),
    .almost_empty(s_ae), .count(s_count), .space(s_space),
    .overflow(s_ovf), .underflow(s_unf)
  );

  req_fifo_ctl #(.WIDTH(W), .DEPTH(D), .FWFT(1)) u_fwft (
    .clk(clk), .reset_n(reset_n), .wr(wr), .w_data(w_data), .rd(rd),
    .clr_err(clr_err), .r_data(f_rdata), .r_data_valid(f_valid),
    .full(f_full), .empty(f_empty), .almost_full(f_af),
    .almost_empty(f_ae), .count(f_count), .space(f_space),
    .overflow(f_ovf), .underflow(f_unf)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: scoreboard queues of words held.
  logic [W-1:0] sq[$];
  logic [W-1:0] fq[$];
  logic [W-1:0] m_s_rd, m_fh;
  logic         m_s_v, m_fhv, m_s_ovf, m_s_unf, m_f_ovf, m_f_unf;

  typedef struct {
    logic         wr, rd, clr;
    logic [W-1:0] data;
    int           e_count;
    logic         e_empty, e_valid;
    logic [W-1:0] e_rdata;
    logic         e_unf, e_ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at it.
  task automatic model_edge();
    int  sc;
    bit  wacc, racc, load;
    if (!reset_n) begin
      sq.delete(); fq.delete();
      m_s_rd = '0; m_s_v = 1'b0; m_s_ovf = 1'b0; m_s_unf = 1'b0;
      m_fh = '0; m_fhv = 1'b0; m_f_ovf = 1'b0; m_f_unf = 1'b0;
      return;
    end
    sc      = sq.size();
    wacc    = wr && (sc < CAP);
    racc    = rd && (sc > 0);
    m_s_ovf = (m_s_ovf && !clr_err) || (wr && sc == CAP);
    m_s_unf = (m_s_unf && !clr_err) || (rd && sc == 0);
    m_s_v   = racc;
    if (racc) m_s_rd = sq.pop_front();
    if (wacc) sq.push_back(w_data);

    sc      = fq.size() + int'(m_fhv);
    wacc    = wr && (sc < CAP);
    racc    = rd && m_fhv;
    m_f_ovf = (m_f_ovf && !clr_err) || (wr && sc == CAP);
    m_f_unf = (m_f_unf && !clr_err) || (rd && !m_fhv);
    load    = (!m_fhv || racc) && (fq.size() > 0);
    if (load) begin
      m_fh  = fq.pop_front();
      m_fhv = 1'b1;
    end else if (racc) begin
      m_fhv = 1'b0;
    end
    if (wacc) fq.push_back(w_data);
  endtask

  task automatic check_model();
    int sc, fc;
    sc = sq.size();
    fc = fq.size() + int'(m_fhv);
    chk("s_count", 64'(s_count), 64'(sc));
    chk("s_space", 64'(s_space), 64'(CAP - sc));
    chk("s_full",  64'(s_full),  64'(sc == CAP));
    chk("s_empty", 64'(s_empty), 64'(sc == 0));
    chk("s_af",    64'(s_af),    64'(sc >= CAP - 4));
    chk("s_ae",    64'(s_ae),    64'(sc <= 2));
    chk("s_valid", 64'(s_valid), 64'(m_s_v));
    chk("s_rdata", s_rdata, m_s_rd);
    chk("s_ovf",   64'(s_ovf),   64'(m_s_ovf));
    chk("s_unf",   64'(s_unf),   64'(m_s_unf));
    chk("f_count", 64'(f_count), 64'(fc));
    chk("f_space", 64'(f_space), 64'(CAP - fc));
    chk("f_full",  64'(f_full),  64'(fc == CAP));
    chk("f_empty", 64'(f_empty), 64'(!m_fhv));
    chk("f_af",    64'(f_af),    64'(fc >= CAP - 4));
    chk("f_ae",    64'(f_ae),    64'(fc <= 2));
    chk("f_valid", 64'(f_valid), 64'(m_fhv));
    chk("f_rdata", f_rdata, m_fh);
    chk("f_ovf",   64'(f_ovf),   64'(m_f_ovf));
    chk("f_unf",   64'(f_unf),   64'(m_f_unf));
  endtask

  // One clock edge: update the model, then sample the DUTs 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic idle();
    wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
  endtask

  task automatic do_reset(input int n);
    idle();
    reset_n = 1'b0;
    repeat (n) tick();
    reset_n = 1'b1;
    chk("rst_count", 64'(s_count), 64'd0);
    chk("rst_space", 64'(s_space), 64'd64);
    chk("rst_empty", 64'(s_empty), 64'd1);
    chk("rst_full",  64'(s_full),  64'd0);
    chk("rst_ae",    64'(s_ae),    64'd1);
    chk("rst_af",    64'(s_af),    64'd0);
    chk("rst_valid", 64'(s_valid), 64'd0);
    chk("rst_rdata", s_rdata, 64'd0);
    chk("rst_errs",  64'({s_ovf, s_unf, f_ovf, f_unf}), 64'd0);
    chk("rst_f_empty", 64'(f_empty), 64'd1);
    chk("rst_f_valid", 64'(f_valid), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] exp_w;
    logic [W-1:0] fw_exp[8];

    // wr, rd, clr, data, count, empty, valid, rdata, underflow, overflow
    vecs[0] = '{1'b1, 1'b1, 1'b0, 64'h11, 1, 1'b0, 1'b0, 64'h0,  1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 64'h0,  1, 1'b0, 1'b0, 64'h0,  1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 64'h22, 2, 1'b0, 1'b0, 64'h0,  1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 64'h0,  1, 1'b0, 1'b1, 64'h11, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 64'h0,  0, 1'b1, 1'b1, 64'h22, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 64'h0,  0, 1'b1, 1'b0, 64'h22, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 64'h0,  0, 1'b1, 1'b0, 64'h22, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 64'h0,  0, 1'b1, 1'b0, 64'h22, 1'b0, 1'b0};

    // Reset, then the empty-corner / error-flag vector table.
    do_reset(2);
    for (int i = 0; i < 8; i++) begin
      wr = vecs[i].wr; rd = vecs[i].rd; clr_err = vecs[i].clr; w_data = vecs[i].data;
      tick();
      chk($sformatf("vec%0d_count", i), 64'(s_count), 64'(vecs[i].e_count));
      chk($sformatf("vec%0d_empty", i), 64'(s_empty), 64'(vecs[i].e_empty));
      chk($sformatf("vec%0d_valid", i), 64'(s_valid), 64'(vecs[i].e_valid));
      chk($sformatf("vec%0d_rdata", i), s_rdata, vecs[i].e_rdata);
      chk($sformatf("vec%0d_unf", i),   64'(s_unf),   64'(vecs[i].e_unf));
      chk($sformatf("vec%0d_ovf", i),   64'(s_ovf),   64'(vecs[i].e_ovf));
      $display("vec %0d: wr=%0d rd=%0d clr=%0d count=%0d valid=%0d rdata=%0h unf=%0d",
               i, wr, rd, clr_err, s_count, s_valid, s_rdata, s_unf);
    end
    idle();

    // Fill to full, overflow attempt, drain in order.
    do_reset(2);
    for (int i = 0; i < CAP; i++) begin
      wr = 1'b1; w_data = 64'(i);
      tick();
      if (i == 58) chk("af_before_60", 64'(s_af), 64'd0);
      if (i == 59) chk("af_at_60",     64'(s_af), 64'd1);
      if (i == 62) chk("full_early",   64'(s_full), 64'd0);
    end
    chk("full_at_64", 64'(s_full), 64'd1);
    chk("space_at_64", 64'(s_space), 64'd0);
    $display("fill: count=%0d space=%0d full=%0d", s_count, s_space, s_full);
    w_data = 64'hDEAD;
    tick();
    chk("ovf_count", 64'(s_count), 64'd64);
    chk("ovf_flag",  64'(s_ovf),   64'd1);
    wr = 1'b0; rd = 1'b1;
    for (int i = 0; i < CAP; i++) begin
      tick();
      chk("drain_valid", 64'(s_valid), 64'd1);
      chk("drain_data",  s_rdata, 64'(i));
    end
    rd = 1'b0;
    tick();
    chk("drain_end_valid", 64'(s_valid), 64'd0);
    chk("drain_end_empty", 64'(s_empty), 64'd1);
    $display("drain: count=%0d empty=%0d", s_count, s_empty);

    // Wrap-around with a steady 20-word backlog.
    do_reset(2);
    for (int i = 0; i < 40; i++) begin wr = 1'b1; w_data = 64'h100 + 64'(i); tick(); end
    wr = 1'b0; rd = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    rd = 1'b0; wr = 1'b1;
    for (int i = 0; i < 20; i++) begin w_data = 64'h200 + 64'(i); tick(); end
    rd = 1'b1;
    for (int i = 0; i < 100; i++) begin
      w_data = 64'h300 + 64'(i);
      tick();
      exp_w = (i < 20) ? 64'h200 + 64'(i) : 64'h300 + 64'(i - 20);
      chk("wrap_count", 64'(s_count), 64'd20);
      chk("wrap_space", 64'(s_space), 64'd44);
      chk("wrap_data",  s_rdata, exp_w);
    end
    $display("wrap: count=%0d space=%0d last=%0h", s_count, s_space, s_rdata);
    wr = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    rd = 1'b0;
    tick();

    // FWFT latency and back-to-back pops.
    do_reset(2);
    wr = 1'b1; w_data = 64'hA5;
    tick();
    wr = 1'b0;
    chk("fwft_edge1_valid", 64'(f_valid), 64'd0);
    tick();
    chk("fwft_edge2_valid", 64'(f_valid), 64'd1);
    chk("fwft_edge2_data",  f_rdata, 64'hA5);
    fw_exp[0] = 64'hA5;
    wr = 1'b1;
    for (int i = 0; i < 7; i++) begin
      w_data = 64'hB0 + 64'(i); fw_exp[i+1] = w_data;
      tick();
    end
    wr = 1'b0; rd = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("fwft_pop_valid", 64'(f_valid), 64'd1);
      chk("fwft_pop_data",  f_rdata, fw_exp[k]);
      $display("fwft pop %0d: data=%0h valid=%0d", k, f_rdata, f_valid);
      tick();
    end
    rd = 1'b0;
    chk("fwft_after_empty", 64'(f_empty), 64'd1);
    chk("fwft_after_count", 64'(f_count), 64'd0);
    tick();

    // Reset in the middle of traffic.
    do_reset(2);
    wr = 1'b1;
    for (int i = 0; i < 30; i++) begin w_data = 64'h400 + 64'(i); tick(); end
    wr = 1'b0; rd = 1'b1;
    repeat (3) tick();
    do_reset(1);
    tick();
    chk("midrst_s_valid", 64'(s_valid), 64'd0);
    chk("midrst_f_valid", 64'(f_valid), 64'd0);
    wr = 1'b1; w_data = 64'h55AA;
    tick();
    wr = 1'b0; rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("midrst_s_rt_valid", 64'(s_valid), 64'd1);
    chk("midrst_s_rt_data",  s_rdata, 64'h55AA);
    chk("midrst_f_rt_data",  f_rdata, 64'h55AA);
    tick();
    chk("midrst_s_count", 64'(s_count), 64'd0);
    $display("midreset: s_data=%0h f_data=%0h f_count=%0d", s_rdata, f_rdata, f_count);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
